// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared ALU op codes, RV64 opcodes and issue-FSM state type
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    // ALU op encoding is {b3, funct3}
    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SUB  = 4'b1000;
    localparam alu_op_t ALU_SLL  = 4'b0001;
    localparam alu_op_t ALU_SLT  = 4'b0010;
    localparam alu_op_t ALU_SLTU = 4'b0011;
    localparam alu_op_t ALU_XOR  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SRA  = 4'b1101;
    localparam alu_op_t ALU_OR   = 4'b0110;
    localparam alu_op_t ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Brief    : Combinational RV64 OP/OP-IMM decode into ALU op and immediate
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_t     op,
    output logic        use_imm,
    output logic [63:0] b_imm,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register specifiers are handled upstream; only the opcode fields matter here
    logic unused_reg_fields;
    assign unused_reg_fields = &{1'b0, instr[19:15], instr[11:7]};

    // Classify the instruction and derive op / immediate operand
    always_comb begin
        op      = ALU_ADD;
        use_imm = 1'b0;
        b_imm   = {{52{instr[31]}}, instr[31:20]};
        illegal = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    op      = {1'b0, funct3};
                    illegal = 1'b0;
                end else if (funct7 == 7'b0100000 &&
                             (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    op      = {1'b1, funct3};
                    illegal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                op      = {1'b0, funct3};
                illegal = 1'b0;
                if (funct3 == 3'b001) begin
                    // 6-bit shamt; the upper field must be clear
                    b_imm   = {58'd0, instr[25:20]};
                    illegal = (instr[31:26] != 6'b000000);
                end else if (funct3 == 3'b101) begin
                    // instr[30] selects arithmetic vs logical right shift
                    b_imm   = {58'd0, instr[25:20]};
                    op      = {instr[30], 3'b101};
                    illegal = !(instr[31:26] == 6'b000000 ||
                                instr[31:26] == 6'b010000);
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Brief    : Issues one decoded OP/OP-IMM instruction to the 64-bit ALU,
//             waits the settle window and returns the captured result
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_instr,
    input  logic [63:0]      req_rs1_val,
    input  logic [63:0]      req_rs2_val,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    output alu_op_t          alu_op,
    input  logic [63:0]      alu_out,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] cnt_issued,
    output logic [CNT_W-1:0] cnt_illegal
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  settle_cnt;

    alu_op_t     dec_op;
    logic        dec_use_imm;
    logic [63:0] dec_b_imm;
    logic        dec_illegal;

    logic        accept;
    logic        settle_done;

    alu_op_decode u_decode (
        .instr   (req_instr),
        .op      (dec_op),
        .use_imm (dec_use_imm),
        .b_imm   (dec_b_imm),
        .illegal (dec_illegal)
    );

    assign req_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign accept      = req_valid && req_ready;
    assign settle_done = (settle_cnt == 4'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state logic: accept, settle, then hold until handshake
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = dec_illegal ? ST_RESP : ST_DRIVE;
            ST_DRIVE: if (settle_done) next_state = ST_RESP;
            ST_RESP:  if (rsp_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Operand, response, settle-counter and event-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= ALU_ADD;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            settle_cnt  <= 4'd0;
            cnt_issued  <= '0;
            cnt_illegal <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!dec_illegal) begin
                            alu_a      <= req_rs1_val;
                            alu_b      <= dec_use_imm ? dec_b_imm : req_rs2_val;
                            alu_op     <= dec_op;
                            settle_cnt <= SETTLE_LOAD;
                            cnt_issued <= cnt_issued + CNT_W'(1);
                        end else begin
                            // ALU operands deliberately left untouched
                            rsp_illegal <= 1'b1;
                            rsp_result  <= '0;
                            rsp_zero    <= 1'b0;
                            cnt_illegal <= cnt_illegal + CNT_W'(1);
                        end
                    end
                end
                ST_DRIVE: begin
                    if (settle_done) begin
                        rsp_result  <= alu_out;
                        rsp_zero    <= alu_zero;
                        rsp_illegal <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Brief    : Directed self-checking bench for alu_issue_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rst_n3;
    logic        req_valid, rsp_ready;
    logic [31:0] req_instr;
    logic [63:0] req_rs1_val, req_rs2_val;

    logic        req_ready, rsp_valid, rsp_zero, rsp_illegal, alu_zero;
    logic [63:0] alu_a, alu_b, alu_out, rsp_result;
    logic [3:0]  alu_op;
    logic [15:0] cnt_issued, cnt_illegal;

    logic        req_ready3, rsp_valid3, rsp_zero3, rsp_illegal3, alu_zero3;
    logic [63:0] alu_a3, alu_b3, alu_out3, rsp_result3;
    logic [3:0]  alu_op3;
    logic [15:0] cnt_issued3, cnt_illegal3;

    int errors = 0;
    int checks = 0;
    int exp_iss = 0;
    int exp_ill = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the 64-bit ALU
    function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[5:0];
            4'b0010: return {63'd0, $signed(a) < $signed(b)};
            4'b0011: return {63'd0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[5:0];
            4'b1101: return $signed(a) >>> b[5:0];
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 64'd0;
        endcase
    endfunction

    assign alu_out   = alu_f(alu_a, alu_b, alu_op);
    assign alu_zero  = (alu_out == 64'd0);
    assign alu_out3  = alu_f(alu_a3, alu_b3, alu_op3);
    assign alu_zero3 = (alu_out3 == 64'd0);

    alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_rs1_val(req_rs1_val), .req_rs2_val(req_rs2_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .cnt_issued(cnt_issued), .cnt_illegal(cnt_illegal)
    );

    alu_issue_ctrl #(.SETTLE_CYCLES(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .req_valid(req_valid), .req_ready(req_ready3),
        .req_instr(req_instr), .req_rs1_val(req_rs1_val), .req_rs2_val(req_rs2_val),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_out(alu_out3), .alu_zero(alu_zero3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_result3),
        .rsp_zero(rsp_zero3), .rsp_illegal(rsp_illegal3),
        .cnt_issued(cnt_issued3), .cnt_illegal(cnt_illegal3)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one request to u_dut, accept it, then verify response latency
    task automatic issue(input logic [31:0] instr, input logic [63:0] rs1,
                         input logic [63:0] rs2, input int lat);
        @(negedge clk);
        req_valid = 1'b1; req_instr = instr; req_rs1_val = rs1; req_rs2_val = rs2;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_instr = 32'h0; req_rs1_val = ~rs1; req_rs2_val = ~rs2;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("rsp_valid_early", {63'd0, rsp_valid}, 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        check("rsp_valid_on_time", {63'd0, rsp_valid}, 64'd1);
    endtask

    // Complete the response handshake and confirm the return to idle
    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("idle_ready", {63'd0, req_ready}, 64'd1);
        check("idle_valid", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rst_n3 = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_instr = 32'h0; req_rs1_val = 64'd0; req_rs2_val = 64'd0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_alu_a", alu_a, 64'd0);
        check("rst_cnt_issued", {48'd0, cnt_issued}, 64'd0);
        rst_n = 1'b1;

        // 1. add 1+2
        issue(32'h002081B3, 64'd1, 64'd2, 1);
        exp_iss++;
        check("add_result", rsp_result, 64'd3);
        check("add_zero", {63'd0, rsp_zero}, 64'd0);
        check("add_illegal", {63'd0, rsp_illegal}, 64'd0);
        check("add_cnt", {48'd0, cnt_issued}, 64'(exp_iss));
        finish_rsp();

        // 2. sub
        issue(32'h402081B3, 64'd2, 64'd2, 1);
        exp_iss++;
        check("sub0_result", rsp_result, 64'd0);
        check("sub0_zero", {63'd0, rsp_zero}, 64'd1);
        check("sub0_op", {60'd0, alu_op}, 64'h8);
        finish_rsp();
        issue(32'h402081B3, 64'd4, 64'd5, 1);
        exp_iss++;
        check("sub1_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub1_zero", {63'd0, rsp_zero}, 64'd0);
        finish_rsp();

        // 3. addi -1, then srai 63
        issue(32'hFFF08093, 64'd0, 64'd123, 1);
        exp_iss++;
        check("addi_b", alu_b, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        finish_rsp();
        issue(32'h43F0D093, 64'h8000_0000_0000_0000, 64'd5, 1);
        exp_iss++;
        check("srai_op", {60'd0, alu_op}, 64'hD);
        check("srai_b", alu_b, 64'd63);
        check("srai_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        finish_rsp();

        // 4. illegal: jal, OP funct7=0100000 funct3=100, W-variant
        issue(32'h0000006F, 64'd11, 64'd22, 0);
        exp_ill++;
        check("jal_illegal", {63'd0, rsp_illegal}, 64'd1);
        finish_rsp();
        issue(32'h4020C1B3, 64'd33, 64'd44, 0);
        exp_ill++;
        check("f7x_illegal", {63'd0, rsp_illegal}, 64'd1);
        check("f7x_result", rsp_result, 64'd0);
        check("f7x_zero", {63'd0, rsp_zero}, 64'd0);
        check("f7x_alu_a", alu_a, 64'h8000_0000_0000_0000);
        check("f7x_alu_b", alu_b, 64'd63);
        check("f7x_alu_op", {60'd0, alu_op}, 64'hD);
        check("f7x_cnt_illegal", {48'd0, cnt_illegal}, 64'(exp_ill));
        finish_rsp();
        issue(32'h002081BB, 64'd1, 64'd1, 0);
        exp_ill++;
        check("addw_illegal", {63'd0, rsp_illegal}, 64'd1);
        check("addw_cnt_illegal", {48'd0, cnt_illegal}, 64'(exp_ill));
        check("addw_cnt_issued", {48'd0, cnt_issued}, 64'(exp_iss));
        finish_rsp();

        // 5. backpressure with a pending request
        issue(32'h002081B3, 64'd5, 64'd6, 1);
        exp_iss++;
        req_valid = 1'b1; req_instr = 32'h402081B3; req_rs1_val = 64'd9; req_rs2_val = 64'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_result", rsp_result, 64'd11);
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_hs", {63'd0, req_ready}, 64'd1);
        check("bp_not_yet_accepted", {48'd0, cnt_issued}, 64'(exp_iss));
        @(posedge clk);
        #1 req_valid = 1'b0; req_rs1_val = 64'd0;
        exp_iss++;
        @(negedge clk);
        check("bp_accepted", {48'd0, cnt_issued}, 64'(exp_iss));
        check("bp_drive_valid", {63'd0, rsp_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_pending_valid", {63'd0, rsp_valid}, 64'd1);
        check("bp_pending_result", rsp_result, 64'd5);
        finish_rsp();

        // 6. SETTLE_CYCLES=3 latency, then async reset in the 2nd DRIVE cycle
        rst_n3 = 1'b1;
        @(negedge clk);
        check("d3_rst_ready", {63'd0, req_ready3}, 64'd1);
        req_valid = 1'b1; req_instr = 32'h002081B3; req_rs1_val = 64'd7; req_rs2_val = 64'd8;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("d3_early", {63'd0, rsp_valid3}, 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        check("d3_valid", {63'd0, rsp_valid3}, 64'd1);
        check("d3_result", rsp_result3, 64'd15);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_instr = 32'h002081B3; req_rs1_val = 64'd1; req_rs2_val = 64'd1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("d3_pre_rst_a", alu_a3, 64'd1);
        check("d3_pre_rst_cnt", {48'd0, cnt_issued3}, 64'd2);
        check("d1_pre_rst_valid", {63'd0, rsp_valid}, 64'd1);
        #1 rst_n3 = 1'b0; rst_n = 1'b0;
        #1;
        check("d3_rst_valid", {63'd0, rsp_valid3}, 64'd0);
        check("d3_rst_alu_a", alu_a3, 64'd0);
        check("d3_rst_alu_b", alu_b3, 64'd0);
        check("d3_rst_alu_op", {60'd0, alu_op3}, 64'd0);
        check("d3_rst_cnt", {48'd0, cnt_issued3}, 64'd0);
        check("d1_rst_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        rst_n3 = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        check("d3_post_rst_ready", {63'd0, req_ready3}, 64'd1);
        check("d1_post_rst_ready", {63'd0, req_ready}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
